// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor.
// One DIGIT-bit ripple slice is reused for WIDTH/DIGIT cycles. The carry out of each
// digit is held in a register and fed into the next digit. The result fills from the
// MSB side, so after the last digit the low-order digit sits at the bottom of sum.
// The handshake is start -> busy for N cycles -> a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    // Reject geometries the serial datapath cannot handle.
    generate
        if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
            $error("serial_adder: DIGIT must divide WIDTH exactly and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    // Digit slice: the carry chain c[0..DIGIT] ripples through DIGIT full adders.
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] digit_sum;
    logic             slice_ovf;

    assign c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
            assign digit_sum[gi] = a_reg[gi] ^ b_reg[gi] ^ c[gi];
            assign c[gi+1]       = (a_reg[gi] & b_reg[gi]) | (a_reg[gi] & c[gi]) | (b_reg[gi] & c[gi]);
        end
    endgenerate

    // Overflow is meaningful only on the final digit, where slice bit DIGIT-1 is the operand MSB.
    assign slice_ovf = c[DIGIT] ^ c[DIGIT-1];

    // Shifted operand and result images for the next digit. A single-digit
    // configuration has nothing left to shift.
    logic [WIDTH-1:0] a_shift, b_shift, sum_shift;

    generate
        if (DIGIT == WIDTH) begin : g_single_digit
            assign a_shift   = '0;
            assign b_shift   = '0;
            assign sum_shift = digit_sum;
        end else begin : g_multi_digit
            assign a_shift   = {{DIGIT{1'b0}}, a_reg[WIDTH-1:DIGIT]};
            assign b_shift   = {{DIGIT{1'b0}}, b_reg[WIDTH-1:DIGIT]};
            assign sum_shift = {digit_sum, sum_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Next-state and datapath control: accept in IDLE/DONE, step one digit per RUN cycle.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Subtraction becomes a + ~b + 1. The +1 enters through the carry register.
                    a_next     = a;
                    b_next     = b ^ {WIDTH{sub}};
                    carry_next = sub ? 1'b1 : cin;
                    cnt_next   = '0;
                    state_next = S_RUN;
                end else if (state_reg == S_DONE) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                a_next     = a_shift;
                b_next     = b_shift;
                sum_next   = sum_shift;
                carry_next = c[DIGIT];
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_DIGIT) begin
                    cout_next  = c[DIGIT];
                    ovf_next   = slice_ovf;
                    cnt_next   = '0;
                    state_next = S_DONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy = (state_reg == S_RUN);
    assign done = (state_reg == S_DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder in four geometries: (8,1), (8,2), (16,4), (32,32).
module tb_serial_adder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  start;
    logic        sub_in;
    logic        cin_in;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [3:0]  cout;
    logic [3:0]  ovf;
    logic [7:0]  sum0;
    logic [7:0]  sum1;
    logic [15:0] sum2;
    logic [31:0] sum3;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin_in), .busy(busy[0]), .done(done[0]), .sum(sum0), .cout(cout[0]), .ovf(ovf[0]));

    serial_adder #(.WIDTH(8), .DIGIT(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub_in), .a(a_in[7:0]), .b(b_in[7:0]),
        .cin(cin_in), .busy(busy[1]), .done(done[1]), .sum(sum1), .cout(cout[1]), .ovf(ovf[1]));

    serial_adder #(.WIDTH(16), .DIGIT(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]),
        .cin(cin_in), .busy(busy[2]), .done(done[2]), .sum(sum2), .cout(cout[2]), .ovf(ovf[2]));

    serial_adder #(.WIDTH(32), .DIGIT(32)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .sub(sub_in), .a(a_in), .b(b_in),
        .cin(cin_in), .busy(busy[3]), .done(done[3]), .sum(sum3), .cout(cout[3]), .ovf(ovf[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int width_of(input int k);
        case (k)
            0: return 8;
            1: return 8;
            2: return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int n_of(input int k);
        case (k)
            0: return 8;
            1: return 4;
            2: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] get_sum(input int k);
        case (k)
            0: return {24'd0, sum0};
            1: return {24'd0, sum1};
            2: return {16'd0, sum2};
            default: return sum3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference arithmetic in 64 bits. Overflow comes from the sign rule, not from carries.
    task automatic ref_model(input int k, input logic [31:0] av, input logic [31:0] bv,
                             input logic ci, input logic sb,
                             output logic [31:0] s, output logic co, output logic ov);
        int          w;
        logic [63:0] mask, aa, bb, full, ss;
        w    = width_of(k);
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, av} & mask;
        bb   = (sb ? ~{32'd0, bv} : {32'd0, bv}) & mask;
        full = aa + bb + (sb ? 64'd1 : {63'd0, ci});
        ss   = full & mask;
        s    = ss[31:0];
        co   = full[w];
        ov   = (aa[w-1] == bb[w-1]) && (ss[w-1] != aa[w-1]);
    endtask

    // Launch one operation on instance k and wait (bounded) for done.
    // lat counts edges from the accept edge to the done cycle. bsy counts busy cycles seen.
    // With disturb set, start is pulsed and the operands are scrambled mid-run.
    task automatic run_op(input int k, input logic [31:0] av, input logic [31:0] bv,
                          input logic ci, input logic sb, input bit disturb,
                          output logic [31:0] s, output logic co, output logic ov,
                          output int lat, output int bsy);
        int j;
        @(negedge clk);
        a_in     = av;
        b_in     = bv;
        cin_in   = ci;
        sub_in   = sb;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        j   = 0;
        bsy = 0;
        while ((j < 64) && !done[k]) begin
            if (busy[k]) bsy++;
            if (disturb && (j == 2)) begin
                start[k] = 1'b1;
                a_in     = ~a_in;
                b_in     = b_in ^ 32'h5A5A_5A5A;
                sub_in   = ~sub_in;
                cin_in   = ~cin_in;
            end
            if (disturb && (j == 3)) start[k] = 1'b0;
            @(negedge clk);
            j++;
        end
        lat = j;
        s   = get_sum(k);
        co  = cout[k];
        ov  = ovf[k];
        if (j >= 64) begin
            checks++;
            errors++;
            $error("FAIL timeout_k%0d observed=no_done expected=done", k);
        end
        check("busy_low_at_done", {31'd0, busy[k]}, 32'd0);
        $display("op k=%0d a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d lat=%0d busy=%0d",
                 k, av, bv, ci, sb, s, co, ov, lat, bsy);
    endtask

    initial begin
        logic [31:0] s, es;
        logic        co, ov, eco, eov;
        int          lat, bsy, ndone, nbusy;
        logic [31:0] av, bv;
        logic        ci, sb;

        start  = '0;
        sub_in = 1'b0;
        cin_in = 1'b0;
        a_in   = '0;
        b_in   = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state of all instances
        check("reset_flags", {16'd0, busy, done, cout, ovf}, 32'd0);
        check("reset_sum01", {16'd0, sum0, sum1}, 32'd0);
        check("reset_sum23", sum3 | {16'd0, sum2}, 32'd0);
        rst_n = 1'b1;

        // 8/1: FF + 01 wraps to 00 with carry out
        run_op(0, 32'hFF, 32'h01, 1'b0, 1'b0, 1'b0, s, co, ov, lat, bsy);
        check("t1_sum", s, 32'h00);
        check("t1_cout", {31'd0, co}, 32'd1);
        check("t1_ovf", {31'd0, ov}, 32'd0);
        check("t1_lat", lat, 8);
        check("t1_busy", bsy, 8);

        // 8/1: 7F + 01 overflows positive into negative
        run_op(0, 32'h7F, 32'h01, 1'b0, 1'b0, 1'b0, s, co, ov, lat, bsy);
        check("t2a_sum", s, 32'h80);
        check("t2a_cout", {31'd0, co}, 32'd0);
        check("t2a_ovf", {31'd0, ov}, 32'd1);

        // 8/1: 05 - 07 = FE with a borrow (cout 0). cin is ignored in subtract mode.
        run_op(0, 32'h05, 32'h07, 1'b1, 1'b1, 1'b0, s, co, ov, lat, bsy);
        check("t2b_sum", s, 32'hFE);
        check("t2b_cout", {31'd0, co}, 32'd0);
        check("t2b_ovf", {31'd0, ov}, 32'd0);

        // 16/4: 1234 + 0FFF + 1 = 2234
        run_op(2, 32'h1234, 32'h0FFF, 1'b1, 1'b0, 1'b0, s, co, ov, lat, bsy);
        check("t3_sum", s, 32'h2234);
        check("t3_cout", {31'd0, co}, 32'd0);
        check("t3_ovf", {31'd0, ov}, 32'd0);
        check("t3_lat", lat, 4);
        check("t3_busy", bsy, 4);

        // 8/2: 80 - 01 = 7F, signed overflow, no borrow
        run_op(1, 32'h80, 32'h01, 1'b0, 1'b1, 1'b0, s, co, ov, lat, bsy);
        check("t8_2_sum", s, 32'h7F);
        check("t8_2_cout", {31'd0, co}, 32'd1);
        check("t8_2_ovf", {31'd0, ov}, 32'd1);
        check("t8_2_lat", lat, 4);

        // 32/32: single digit, done in the cycle after the accept edge
        run_op(3, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, s, co, ov, lat, bsy);
        check("t32_sum", s, 32'h0);
        check("t32_cout", {31'd0, co}, 32'd1);
        check("t32_lat", lat, 1);
        check("t32_busy", bsy, 1);

        // Start pulses and operand changes during RUN leave the in-flight op alone
        run_op(0, 32'h3C, 32'h0F, 1'b0, 1'b0, 1'b1, s, co, ov, lat, bsy);
        check("t4_disturb_sum", s, 32'h4B);
        check("t4_disturb_lat", lat, 8);

        // start held high: done every 9 cycles (at 8, 17, 26), busy in 27 of the first 30 cycles
        @(negedge clk);
        a_in     = 32'h03;
        b_in     = 32'h04;
        cin_in   = 1'b0;
        sub_in   = 1'b0;
        start[0] = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy[0]) nbusy++;
            if (done[0]) begin
                check("t4_done_pos", i, 8 + 9 * ndone);
                check("t4_b2b_sum", {24'd0, sum0}, 32'h07);
                ndone++;
            end
        end
        start[0] = 1'b0;
        check("t4_done_count", ndone, 3);
        check("t4_busy_count", nbusy, 27);
        // Let the fourth op drain, with a bounded wait
        for (int i = 0; (i < 20) && !done[0]; i++) @(negedge clk);
        check("t4_drain_done", {31'd0, done[0]}, 32'd1);
        @(negedge clk);

        // Reset in cycle 3 of 8: outputs clear immediately and no done follows
        @(negedge clk);
        a_in     = 32'hFF;
        b_in     = 32'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_partial_busy", {31'd0, busy[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_flags", {28'd0, busy[0], done[0], cout[0], ovf[0]}, 32'd0);
        check("t5_rst_sum", {24'd0, sum0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0]) ndone++;
            if (busy[0]) nbusy++;
        end
        check("t5_no_done", ndone, 0);
        check("t5_no_busy", nbusy, 0);
        run_op(0, 32'h5A, 32'h3C, 1'b1, 1'b0, 1'b0, s, co, ov, lat, bsy);
        check("t5_after_sum", s, 32'h97);
        check("t5_after_cout", {31'd0, co}, 32'd0);
        check("t5_after_ovf", {31'd0, ov}, 32'd1);

        // Random operations against the reference model, 1000 per geometry
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 1000; n++) begin
                av = $urandom;
                bv = $urandom;
                ci = 1'($urandom_range(0, 1));
                sb = 1'($urandom_range(0, 1));
                run_op(k, av, bv, ci, sb, 1'b0, s, co, ov, lat, bsy);
                ref_model(k, av, bv, ci, sb, es, eco, eov);
                check("rnd_sum", s, es);
                check("rnd_cout", {31'd0, co}, {31'd0, eco});
                check("rnd_ovf", {31'd0, ov}, {31'd0, eov});
                check("rnd_lat", lat, n_of(k));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
